// File: rtl/wave_mixer_pkg.sv
// Shared types and helpers for the wave_mixer mixing stage.
// Optional feature macro: WAVE_MIXER_DC_BLOCK_EN (adds the DC-blocking filter stage).
package wave_mixer_pkg;

    localparam int SAT_INW = 48;

`ifdef WAVE_MIXER_DC_BLOCK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2,
        ST_FILT  = 2'd3
    } mix_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_SAT   = 2'd2
    } mix_state_t;
`endif

    typedef struct packed {
        logic        clip;
        logic [15:0] val;
    } sat16_t;

    // Accumulator width: full product width plus headroom for summing nch products.
    function automatic int acc_width(input int nch, input int volw);
        return 17 + volw + $clog2(nch);
    endfunction

    // Clamp a sign-extended value into signed 16 bits, flagging when the clamp engages.
    function automatic sat16_t sat16(input logic signed [SAT_INW-1:0] x);
        localparam logic signed [SAT_INW-1:0] MAXV = SAT_INW'(32767);
        localparam logic signed [SAT_INW-1:0] MINV = -SAT_INW'(32768);
        sat16_t r;
        if (x > MAXV) begin
            r.clip = 1'b1;
            r.val  = 16'h7FFF;
        end else if (x < MINV) begin
            r.clip = 1'b1;
            r.val  = 16'h8000;
        end else begin
            r.clip = 1'b0;
            r.val  = x[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/wave_mixer_dc_block.sv
// One-pole DC-blocking high-pass applied to each mixed sample.
// Present only when WAVE_MIXER_DC_BLOCK_EN is defined.
`ifdef WAVE_MIXER_DC_BLOCK_EN
module wave_dc_block
    import wave_mixer_pkg::*;
(
    input  logic        I_CLK,
    input  logic        I_RST,
    input  logic        I_STEP,
    input  logic [15:0] I_X,
    output logic [15:0] O_Y,
    output logic        O_CLIP
);

    localparam int FW = 20;
    localparam logic signed [FW-1:0] ST_MAX = FW'(131071);
    localparam logic signed [FW-1:0] ST_MIN = -FW'(131072);

    logic signed [17:0]   x_prev;
    logic signed [17:0]   y_prev;
    logic signed [FW-1:0] y_full;
    logic signed [FW-1:0] y_state;
    sat16_t               y_sat;

    // Filter difference equation, 18-bit clamp for the stored state and 16-bit clamp for the output.
    always_comb begin
        y_full = FW'($signed(I_X)) - FW'(x_prev) + FW'(y_prev) - FW'(y_prev >>> 8);
        if (y_full > ST_MAX) begin
            y_state = ST_MAX;
        end else if (y_full < ST_MIN) begin
            y_state = ST_MIN;
        end else begin
            y_state = y_full;
        end
        y_sat  = sat16(SAT_INW'(y_full));
        O_Y    = y_sat.val;
        O_CLIP = y_sat.clip;
    end

    // Advance the filter history once per mixed sample.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            x_prev <= '0;
            y_prev <= '0;
        end else if (I_STEP) begin
            x_prev <= {{2{I_X[15]}}, I_X};
            y_prev <= y_state[17:0];
        end
    end

endmodule
`endif

// File: rtl/wave_mixer.sv
// Time-multiplexed mixer: snapshots NCH channel samples on each output tick,
// accumulates volume-scaled products one channel per cycle, then saturates to 16 bits.
// Optional feature macro: WAVE_MIXER_DC_BLOCK_EN (DC-blocking filter after saturation).
module wave_mixer
    import wave_mixer_pkg::*;
#(
    parameter int NCH  = 8,
    parameter int VOLW = 4
) (
    input  logic                I_CLK,
    input  logic                I_RST,
    input  logic                I_SAMPLE_TICK,
    input  logic [NCH*16-1:0]   I_CH_SND,
    input  logic [NCH*VOLW-1:0] I_CH_VOL,
    input  logic [NCH-1:0]      I_CH_EN,
    output logic [15:0]         O_SND,
    output logic                O_SND_VALID,
    output logic                O_CLIP,
    output logic                O_BUSY
);

    localparam int ACCW  = acc_width(NCH, VOLW);
    localparam int PRODW = 17 + VOLW;
    localparam int CHW   = $clog2(NCH);

    mix_state_t               state;
    logic [NCH*16-1:0]        snd_q;
    logic [NCH*VOLW-1:0]      vol_q;
    logic [NCH-1:0]           en_q;
    logic signed [ACCW-1:0]   acc;
    logic [CHW-1:0]           ch;

    logic [15:0]              cur_snd;
    logic [VOLW-1:0]          cur_vol;
    logic                     cur_en;
    logic signed [PRODW-1:0]  prod;
    logic signed [ACCW-1:0]   term;
    logic signed [ACCW-1:0]   shifted;
    sat16_t                   sat_res;

`ifdef WAVE_MIXER_DC_BLOCK_EN
    logic [15:0] x_sat;
    logic        clip_sat;
    logic [15:0] filt_y;
    logic        filt_clip;
    logic        filt_step;

    assign filt_step = (state == ST_FILT);

    wave_dc_block u_dc_block (
        .I_CLK  (I_CLK),
        .I_RST  (I_RST),
        .I_STEP (filt_step),
        .I_X    (x_sat),
        .O_Y    (filt_y),
        .O_CLIP (filt_clip)
    );
`endif

    // Select the current channel from the snapshot and form its scaled contribution and the final clamp.
    always_comb begin
        cur_snd = snd_q[ch*16 +: 16];
        cur_vol = vol_q[ch*VOLW +: VOLW];
        cur_en  = en_q[ch];
        prod    = $signed({{(PRODW-16){cur_snd[15]}}, cur_snd})
                * $signed({{(PRODW-VOLW){1'b0}}, cur_vol});
        term    = cur_en ? {{(ACCW-PRODW){prod[PRODW-1]}}, prod} : '0;
        shifted = acc >>> VOLW;
        sat_res = sat16({{(SAT_INW-ACCW){shifted[ACCW-1]}}, shifted});
    end

    // Mixing sequencer with registered outputs: snapshot, accumulate per channel, saturate, publish.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= ST_IDLE;
            snd_q       <= '0;
            vol_q       <= '0;
            en_q        <= '0;
            acc         <= '0;
            ch          <= '0;
            O_SND       <= '0;
            O_SND_VALID <= 1'b0;
            O_CLIP      <= 1'b0;
            O_BUSY      <= 1'b0;
`ifdef WAVE_MIXER_DC_BLOCK_EN
            x_sat       <= '0;
            clip_sat    <= 1'b0;
`endif
        end else begin
            O_SND_VALID <= 1'b0;
            O_CLIP      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_SAMPLE_TICK) begin
                        snd_q  <= I_CH_SND;
                        vol_q  <= I_CH_VOL;
                        en_q   <= I_CH_EN;
                        acc    <= '0;
                        ch     <= '0;
                        O_BUSY <= 1'b1;
                        state  <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc + term;
                    if (ch == CHW'(NCH-1)) begin
                        state <= ST_SAT;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                ST_SAT: begin
`ifdef WAVE_MIXER_DC_BLOCK_EN
                    x_sat    <= sat_res.val;
                    clip_sat <= sat_res.clip;
                    state    <= ST_FILT;
`else
                    O_SND       <= sat_res.val;
                    O_CLIP      <= sat_res.clip;
                    O_SND_VALID <= 1'b1;
                    O_BUSY      <= 1'b0;
                    state       <= ST_IDLE;
`endif
                end
`ifdef WAVE_MIXER_DC_BLOCK_EN
                ST_FILT: begin
                    O_SND       <= filt_y;
                    O_CLIP      <= clip_sat | filt_clip;
                    O_SND_VALID <= 1'b1;
                    O_BUSY      <= 1'b0;
                    state       <= ST_IDLE;
                end
`endif
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
